// File: rtl/mips_16_mem_arbiter.sv
// rtl/mips_16_mem_arbiter.sv - IF/MEM arbiter for a shared single-port fixed-latency memory
//
// Serialises instruction reads (IF) and data reads/writes (MEM) onto one memory
// port, one access at a time: IDLE -> ACCESS -> WAIT (RAM_LAT cycles) -> RESP -> IDLE.
//
// Ports:
//   clk, rst                                   clock (rising edge), async active-low reset
//   if_req, if_addr                            IF read request, held until if_ack
//   if_ack, if_rdata                           IF completion pulse, instruction word
//   mem_req, mem_we, mem_addr, mem_wdata       MEM request, held until mem_ack
//   mem_ack, mem_rdata                         MEM completion pulse, read data
//   ram_en, ram_we, ram_addr, ram_wdata        memory strobe / write enable / address / data
//   ram_rdata                                  memory read data, valid RAM_LAT cycles after ram_en
//   busy                                       arbiter not idle
//
// Configuration macro:
//   MIPS16_ARB_RR_EN  defined   -> round-robin on contention (grant the non-last owner)
//                     undefined -> MEM priority, IF forced after STARVE_MAX starved grants
module mips_16_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RAM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;
  // Counter is loaded in ACCESS and read data is captured when it reaches zero,
  // so loading RAM_LAT-1 yields exactly RAM_LAT WAIT cycles.
  localparam logic [3:0] LAT_M1     = 4'(RAM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [3:0]        starve_q, starve_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              grant_mem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_owner_q <= OWN_IF;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wait_cnt_q   <= '0;
      starve_q     <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_q     <= starve_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wait_cnt_d   = wait_cnt_q;
    starve_d     = starve_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    grant_mem    = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req && mem_req) begin
`ifdef MIPS16_ARB_RR_EN
          grant_mem = (last_owner_q == OWN_IF);
`else
          grant_mem = (starve_q != STARVE_LIM);
`endif
        end else begin
          grant_mem = mem_req;
        end

`ifdef MIPS16_ARB_RR_EN
        starve_d = '0;
`else
        // Count only MEM grants that leave IF waiting; anything else resets the guard.
        if (grant_mem && if_req) begin
          starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
        end else begin
          starve_d = '0;
        end
`endif

        if (if_req || mem_req) begin
          owner_d      = grant_mem;
          last_owner_d = grant_mem;
          we_d         = grant_mem & mem_we;
          addr_d       = grant_mem ? mem_addr : if_addr;
          if (grant_mem) begin
            wdata_d = mem_wdata;
          end
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        wait_cnt_d = LAT_M1;
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          if (!we_q) begin
            if (owner_q == OWN_MEM) begin
              mem_rdata_d = ram_rdata;
            end else begin
              if_rdata_d = ram_rdata;
            end
          end
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registers so reset clears them asynchronously.
  assign ram_en    = (state_q == ACCESS);
  assign ram_we    = we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
  assign mem_ack   = (state_q == RESP) && (owner_q == OWN_MEM);
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mips_16_mem_arbiter.sv
// tb/tb_mips_16_mem_arbiter.sv - self-checking bench for mips_16_mem_arbiter
module tb_mips_16_mem_arbiter;

  localparam int LAT      = 2;
  localparam int SMAX     = 4;
  localparam int RAND_CYC = 800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0;
  logic        if_ack;
  logic [15:0] if_rdata;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = 16'h0;
  logic [15:0] mem_wdata = 16'h0;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = 16'h0;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  mips_16_mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .RAM_LAT(LAT), .STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory macro model: read data is driven only during the cycle exactly LAT
  // cycles after the strobe, random otherwise.
  int          cyc = 0;
  int          rd_at = -1000;
  logic [7:0]  rd_addr = 8'h0;
  logic [15:0] ram_mem [0:255];
  bit          loaded = 1'b0;

  function automatic logic [15:0] init_word(int a);
    case (a)
      16'h10:  return 16'hA5A5;
      16'h21:  return 16'h5A5A;
      16'h30:  return 16'h3030;
      16'h31:  return 16'h3131;
      default: return 16'(a * 16'h0101) ^ 16'h1357;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) ram_mem[i] = init_word(i);
      loaded = 1'b1;
    end
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr[7:0]] = ram_wdata;
      else begin
        rd_at   = cyc + LAT;
        rd_addr = ram_addr[7:0];
      end
    end
    ram_rdata = (cyc == rd_at) ? ram_mem[rd_addr] : 16'($urandom);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    if_req = 1'b0;
    mem_req = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Random-phase reference model state
  int          g;
  bit          m_mem, m_rd, e_busy, e_en, e_ack, gm;
  logic [15:0] m_addr, m_wdata, m_data, exp_if_rd, exp_mem_rd;
  bit          if_act, mem_act;
  int          if_gap, mem_gap;
  logic [15:0] ref_mem [0:63];
  bit          exp_tbl [6];
  bit          img_ok;
`ifdef MIPS16_ARB_RR_EN
  bit          m_last_mem;
`else
  int          m_starve;
`endif

  initial begin
    // Reset state
    step();
    chk1("rst_if_ack", if_ack, 1'b0);
    chk1("rst_mem_ack", mem_ack, 1'b0);
    chk1("rst_ram_en", ram_en, 1'b0);
    chk1("rst_ram_we", ram_we, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk16("rst_ram_addr", ram_addr, 16'h0);
    chk16("rst_ram_wdata", ram_wdata, 16'h0);
    chk16("rst_if_rdata", if_rdata, 16'h0);
    chk16("rst_mem_rdata", mem_rdata, 16'h0);
    do_reset();

    // Single IF read: ram_en at cycle 1, if_ack at cycle LAT+2
    if_req = 1'b1; if_addr = 16'h0010;
    step();
    chk1("if1_ram_en", ram_en, 1'b1);
    chk16("if1_ram_addr", ram_addr, 16'h0010);
    chk1("if1_ram_we", ram_we, 1'b0);
    chk1("if1_busy", busy, 1'b1);
    step(); chk1("if1_ack_c2", if_ack, 1'b0);
    step(); chk1("if1_ack_c3", if_ack, 1'b0);
    step();
    chk1("if1_ack_c4", if_ack, 1'b1);
    chk1("if1_mem_ack", mem_ack, 1'b0);
    chk16("if1_rdata", if_rdata, 16'hA5A5);
    if_req = 1'b0;
    step();
    chk1("if1_ack_c5", if_ack, 1'b0);
    chk1("if1_busy_c5", busy, 1'b0);

    // MEM write then read back
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h1234;
    step();
    chk1("wr_ram_en", ram_en, 1'b1);
    chk1("wr_ram_we", ram_we, 1'b1);
    chk16("wr_ram_wdata", ram_wdata, 16'h1234);
    step(); step(); step();
    chk1("wr_mem_ack", mem_ack, 1'b1);
    chk16("wr_mem_rdata_kept", mem_rdata, 16'h0);
    mem_req = 1'b0;
    step();
    mem_req = 1'b1; mem_we = 1'b0;
    step();
    chk1("rd_ram_we", ram_we, 1'b0);
    step(); step(); step();
    chk1("rd_mem_ack", mem_ack, 1'b1);
    chk16("rd_mem_rdata", mem_rdata, 16'h1234);
    mem_req = 1'b0;
    step();

    // MEM req dropped during WAIT: one ack, no second access
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0021;
    step();
    step();
    mem_req = 1'b0;
    step(); chk1("drop_ack_c3", mem_ack, 1'b0);
    step();
    chk1("drop_ack_c4", mem_ack, 1'b1);
    chk16("drop_rdata", mem_rdata, 16'h5A5A);
    for (int i = 0; i < 4; i++) begin
      step();
      chk1("drop_no_en", ram_en, 1'b0);
      chk1("drop_no_ack", mem_ack, 1'b0);
      chk1("drop_idle", busy, 1'b0);
    end

    // Reset asserted mid-WAIT of an IF read
    if_req = 1'b1; if_addr = 16'h0010;
    step();
    step();
    rst = 1'b0;
    #1;
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_ram_en", ram_en, 1'b0);
    chk16("mid_ram_addr", ram_addr, 16'h0);
    chk16("mid_if_rdata", if_rdata, 16'h0);
    chk16("mid_mem_rdata", mem_rdata, 16'h0);
    if_req = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk1("mid_no_ack", if_ack, 1'b0);
      chk1("mid_busy_after", busy, 1'b0);
    end

    // Contention with both requests held continuously from reset
`ifdef MIPS16_ARB_RR_EN
    exp_tbl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_tbl = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`endif
    do_reset();
    if_req = 1'b1; if_addr = 16'h0030;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0031;
    for (int k = 0; k < 6; k++) begin
      for (int s = 1; s <= LAT + 3; s++) begin
        step();
        chk1("cont_if_ack", if_ack, (s == LAT + 2) && !exp_tbl[k]);
        chk1("cont_mem_ack", mem_ack, (s == LAT + 2) && exp_tbl[k]);
        if (s == LAT + 2 && exp_tbl[k]) chk16("cont_mem_rdata", mem_rdata, 16'h3131);
        if (s == LAT + 2 && !exp_tbl[k]) chk16("cont_if_rdata", if_rdata, 16'h3030);
      end
    end
    if_req = 1'b0; mem_req = 1'b0;

    // Randomized traffic against a transaction-level model
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = ram_mem[i];
    g = -100; m_mem = 1'b0; m_rd = 1'b1;
    m_addr = 16'h0; m_wdata = 16'h0; m_data = 16'h0;
    exp_if_rd = 16'h0; exp_mem_rd = 16'h0;
    if_act = 1'b0; mem_act = 1'b0; if_gap = 1; mem_gap = 0;
`ifdef MIPS16_ARB_RR_EN
    m_last_mem = 1'b0;
`else
    m_starve = 0;
`endif
    for (int t = 0; t < RAND_CYC; t++) begin
      // An access granted in idle cycle g strobes at g+1 and acks at g+LAT+2.
      e_busy = (t > g) && (t <= g + LAT + 2);
      e_en   = (t == g + 1);
      e_ack  = (t == g + LAT + 2);
      if (e_ack && m_rd) begin
        if (m_mem) exp_mem_rd = m_data;
        else       exp_if_rd  = m_data;
      end
      chk1("r_busy", busy, e_busy);
      chk1("r_ram_en", ram_en, e_en);
      chk1("r_if_ack", if_ack, e_ack && !m_mem);
      chk1("r_mem_ack", mem_ack, e_ack && m_mem);
      chk16("r_if_rdata", if_rdata, exp_if_rd);
      chk16("r_mem_rdata", mem_rdata, exp_mem_rd);
      if (e_en) begin
        chk16("r_ram_addr", ram_addr, m_addr);
        chk1("r_ram_we", ram_we, !m_rd);
        if (!m_rd) chk16("r_ram_wdata", ram_wdata, m_wdata);
      end

      if (e_ack && !m_mem) begin if_act = 1'b0; if_gap = int'($urandom_range(0, 2)); end
      if (e_ack && m_mem)  begin mem_act = 1'b0; mem_gap = int'($urandom_range(0, 2)); end
      if (!if_act) begin
        if (if_gap == 0) begin
          if_act = 1'b1;
          if_addr = 16'($urandom_range(0, 63));
        end else if_gap--;
      end
      if (!mem_act) begin
        if (mem_gap == 0) begin
          mem_act = 1'b1;
          mem_addr = 16'($urandom_range(0, 63));
          mem_we = 1'($urandom_range(0, 1));
          mem_wdata = 16'($urandom);
        end else mem_gap--;
      end
      if_req = if_act;
      mem_req = mem_act;

      if (t > g + LAT + 2) begin
        if (if_act || mem_act) begin
`ifdef MIPS16_ARB_RR_EN
          gm = (if_act && mem_act) ? !m_last_mem : mem_act;
          m_last_mem = gm;
`else
          gm = (if_act && mem_act) ? (m_starve != SMAX) : mem_act;
          if (gm && if_act) m_starve = (m_starve == SMAX) ? SMAX : m_starve + 1;
          else m_starve = 0;
`endif
          g = t;
          m_mem = gm;
          m_rd = gm ? !mem_we : 1'b1;
          m_addr = gm ? mem_addr : if_addr;
          m_wdata = mem_wdata;
          if (!m_rd) ref_mem[m_addr[5:0]] = m_wdata;
          else m_data = ref_mem[m_addr[5:0]];
        end else begin
`ifndef MIPS16_ARB_RR_EN
          m_starve = 0;
`endif
        end
      end
      step();
    end
    if_req = 1'b0; mem_req = 1'b0;
    for (int i = 0; i < LAT + 4; i++) step();
    img_ok = 1'b1;
    for (int i = 0; i < 64; i++) if (ram_mem[i] !== ref_mem[i]) img_ok = 1'b0;
    chk1("mem_image", img_ok, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
